// File: rtl/fifo_pkg.sv
// Shared fifo constants and the skid-store occupancy type, used by the fifo reader
// and by fifo instantiations that must agree on word width and depth.
package fifo_pkg;

  localparam int unsigned FifoWidth    = 40;
  localparam int unsigned FifoAddrBits = 3;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid store: head/tail registers plus occupancy state, push and pop in any
// combination.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int unsigned width = FifoWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output occ_e             o_occ,
  output logic             o_valid,
  output logic [width-1:0] o_data
);

  occ_e             r_occ;
  occ_e             w_occ_next;
  logic [width-1:0] r_head;
  logic [width-1:0] r_tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_occ <= OccEmpty;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  always_comb begin
    w_occ_next = r_occ;
    if (i_flush) begin
      w_occ_next = OccEmpty;
    end else if (i_push && !i_pop) begin
      case (r_occ)
        OccEmpty: w_occ_next = OccOne;
        OccOne:   w_occ_next = OccTwo;
        default:  w_occ_next = r_occ;
      endcase
    end else if (!i_push && i_pop) begin
      case (r_occ)
        OccTwo:  w_occ_next = OccOne;
        OccOne:  w_occ_next = OccEmpty;
        default: w_occ_next = r_occ;
      endcase
    end
  end

  // Head is always the oldest word; a pop shifts tail into head.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_flush) begin
      if (i_pop) begin
        if (r_occ == OccTwo) begin
          r_head <= r_tail;
          if (i_push) r_tail <= i_data;
        end else if (i_push) begin
          r_head <= i_data;
        end
      end else if (i_push) begin
        if (r_occ == OccEmpty) r_head <= i_data;
        else                   r_tail <= i_data;
      end
    end
  end

  always_comb begin
    o_occ   = r_occ;
    o_valid = (r_occ != OccEmpty);
    o_data  = r_head;
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains an attached fifo into a 2-entry skid store with a valid/ready output.
// Optional transfer counter is built when FIFO_READER_STATS_EN is defined.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned width     = FifoWidth,
  parameter int unsigned addr_bits = FifoAddrBits
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fifo_ren,
  input  logic [width-1:0]   fifo_rdata,
  input  logic [addr_bits:0] fifo_count,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   out_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]        xfer_count
`endif
);

  logic       r_inflight;
  occ_e       w_occ;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_load;

  assign w_pop  = out_valid && out_ready;
  // A word landing during flush is discarded rather than stored.
  assign w_push = r_inflight && !flush;
  assign w_load = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};

  assign fifo_ren = !reset && !flush && (fifo_count != '0) && (w_load < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_ren;
    end
  end

  fifo_reader_skid #(
    .width (width)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (fifo_rdata),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_valid (out_valid),
    .o_data  (out_data)
  );

`ifdef FIFO_READER_STATS_EN
  logic [31:0] r_xfer_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_pop) begin
      r_xfer_count <= r_xfer_count + 32'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-backed fifo model feeds the DUT, and a queue-level
// reference of the reader predicts fifo_ren, out_valid and out_data every cycle.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int unsigned W     = FifoWidth;
  localparam int unsigned AB    = FifoAddrBits;
  localparam int unsigned CW    = AB + 1;
  localparam int unsigned Depth = 1 << AB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          fifo_ren;
  logic          out_valid;
  logic [W-1:0]  fifo_rdata = '0;
  logic [W-1:0]  out_data;
  logic [AB:0]   fifo_count = '0;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]   xfer_count;
`endif

  always #5 clock = ~clock;

  fifo_reader #(
    .width     (W),
    .addr_bits (AB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_count (fifo_count),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] fq[$];      // attached fifo contents
  logic [W-1:0] mq[$];      // reference skid contents, oldest first
  logic [W-1:0] popped[$];  // words accepted downstream
  bit           m_inf = 1'b0;
  logic [W-1:0] m_inf_word = '0;
  bit           m_after_rst = 1'b0;
  int           ren_pulses = 0;
  logic [31:0]  m_xfer = '0;
  logic [W-1:0] words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_fifo(input logic [W-1:0] w);
    if (fq.size() < Depth) fq.push_back(w);
  endtask

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom, $urandom});
  endfunction

  // One clock: drive inputs, compare against the reference, advance both sides.
  task automatic cyc(input bit rst, input bit fl, input bit rdy);
    bit           e_valid;
    bit           e_pop;
    bit           e_ren;
    bit           d_ren;
    logic [W-1:0] front;
    @(negedge clock);
    reset      = rst;
    flush      = fl;
    out_ready  = rdy;
    fifo_count = CW'(fq.size());
    #1;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && rdy;
    e_ren   = !rst && !fl && (fq.size() != 0) &&
              ((mq.size() + int'(m_inf) - int'(e_pop)) < 2);
    check("out_valid", 64'(out_valid), 64'(e_valid));
    if (e_valid) check("out_data", 64'(out_data), 64'(mq[0]));
    if (m_after_rst) check("out_data_after_reset", 64'(out_data), 64'd0);
    check("fifo_ren", 64'(fifo_ren), 64'(e_ren));
`ifdef FIFO_READER_STATS_EN
    check("xfer_count", 64'(xfer_count), 64'(m_xfer));
`endif
    d_ren = fifo_ren;
    if (d_ren) ren_pulses++;
    front = (fq.size() != 0) ? fq[0] : '0;
    @(posedge clock);
    #1;
    if (rst) begin
      mq.delete();
      m_inf  = 1'b0;
      m_xfer = '0;
    end else begin
      if (e_pop) begin
        popped.push_back(mq.pop_front());
        m_xfer++;
      end
      if (fl) mq.delete();
      else if (m_inf) mq.push_back(m_inf_word);
      m_inf      = e_ren;
      m_inf_word = front;
    end
    m_after_rst = rst;
    // Fifo answers the DUT's actual request; garbage otherwise to expose stray captures.
    if (d_ren && fq.size() != 0) fifo_rdata = fq.pop_front();
    else                         fifo_rdata = rand_word();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Bring DUT state out of its power-up value before the reference takes over.
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    m_after_rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_ren", 64'(fifo_ren), 64'd0);

    // Three words streamed with ready held high.
    popped.delete();
    push_fifo(40'h11);
    push_fifo(40'h22);
    push_fifo(40'h33);
    drain(7);
    check("stream_count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      check("stream_w0", 64'(popped[0]), 64'h11);
      check("stream_w1", 64'(popped[1]), 64'h22);
      check("stream_w2", 64'(popped[2]), 64'h33);
    end
    check("stream_idle", 64'(out_valid), 64'd0);

    // Five words, downstream stalled: only two reads issued.
    words.delete();
    for (int i = 0; i < 5; i++) begin
      words.push_back(rand_word());
      push_fifo(words[i]);
    end
    ren_pulses = 0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
    check("stall_ren_pulses", 64'(ren_pulses), 64'd2);
    check("stall_fifo_count", 64'(fifo_count), 64'd3);
    check("stall_head", 64'(out_data), 64'(words[0]));
    popped.delete();
    drain(10);
    check("stall_drained", 64'(popped.size()), 64'd5);

    // Full skid, ready toggled 1,0,1.
    words.delete();
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      words.push_back(rand_word());
      push_fifo(words[i]);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    drain(8);
    check("toggle_count", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) check("toggle_order", 64'(popped[i]), 64'(words[i]));

    // Flush in the cycle after a read: the in-flight word is lost.
    words.delete();
    popped.delete();
    for (int i = 0; i < 3; i++) begin
      words.push_back(rand_word());
      push_fifo(words[i]);
    end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    drain(6);
    check("flush_count", 64'(popped.size()), 64'd2);
    if (popped.size() != 0) check("flush_next_word", 64'(popped[0]), 64'(words[1]));

    // Reset with a word stored and another in flight.
    for (int i = 0; i < 4; i++) push_fifo(rand_word());
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_mid_valid", 64'(out_valid), 64'd0);
    check("reset_mid_data", 64'(out_data), 64'd0);
    drain(8);
    fq.delete();
    drain(3);

`ifdef FIFO_READER_STATS_EN
    dut.r_xfer_count = 32'hFFFF_FFFE;
    m_xfer = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) push_fifo(rand_word());
    drain(6);
    check("xfer_wrap", 64'(xfer_count), 64'h1);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 60) push_fifo(rand_word());
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < 70));
    end
    drain(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
